// File: rtl/input_daemon_if.sv
// rtl/input_daemon_if.sv - ingress word stream and output-daemon bus of one switch input port
//
// Signals:
//   INPUT_PORT / INPUT_VALID / INPUT_READY   ingress word handshake
//   NOBLOCKOBUF_TO_1..4                      {valid, data} head word offered to output daemon k
//   RD_1..4                                  consume strobe from output daemon k
// Modports:
//   master  link and output-daemon side (drives words and consume strobes)
//   slave   input daemon side
interface input_daemon_if;
    logic [31:0] INPUT_PORT;
    logic        INPUT_VALID;
    logic        INPUT_READY;
    logic [32:0] NOBLOCKOBUF_TO_1;
    logic [32:0] NOBLOCKOBUF_TO_2;
    logic [32:0] NOBLOCKOBUF_TO_3;
    logic [32:0] NOBLOCKOBUF_TO_4;
    logic        RD_1;
    logic        RD_2;
    logic        RD_3;
    logic        RD_4;

    modport master (
        output INPUT_PORT, INPUT_VALID, RD_1, RD_2, RD_3, RD_4,
        input  INPUT_READY, NOBLOCKOBUF_TO_1, NOBLOCKOBUF_TO_2,
               NOBLOCKOBUF_TO_3, NOBLOCKOBUF_TO_4
    );

    modport slave (
        input  INPUT_PORT, INPUT_VALID, RD_1, RD_2, RD_3, RD_4,
        output INPUT_READY, NOBLOCKOBUF_TO_1, NOBLOCKOBUF_TO_2,
               NOBLOCKOBUF_TO_3, NOBLOCKOBUF_TO_4
    );
endinterface

// File: rtl/input_daemon.sv
// rtl/input_daemon.sv - switch ingress stage: header parse, destination tagging, tagged-word FIFO
//
// Ports:
//   clk         clock
//   rst         asynchronous active-high reset
//   bus         input_daemon_if.slave: ingress words in, {valid,data} per output daemon out,
//               consume strobes in
//   DROP_COUNT  saturating count of dropped packets (only with INPUT_DAEMON_DROP_CNT_EN)
// Parameters:
//   DEPTH        FIFO depth in words (power of 2, >= 2)
//   MAX_PKT_LEN  largest legal packet length in words, header included
// Optional feature macro: INPUT_DAEMON_DROP_CNT_EN
module input_daemon #(
    parameter int DEPTH       = 16,
    parameter int MAX_PKT_LEN = 255
) (
    input  logic               clk,
    input  logic               rst,
`ifdef INPUT_DAEMON_DROP_CNT_EN
    input_daemon_if.slave      bus,
    output logic [15:0]        DROP_COUNT
`else
    input_daemon_if.slave      bus
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_LEN);

    typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

    // Entry layout: {dest[1:0], data[31:0]}
    logic [33:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    state_t        state;
    logic [15:0]   cnt;
    logic [1:0]    dest_q;

    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic [1:0]    push_dest;
    logic          pop;
    logic [15:0]   hdr_len;
    logic [1:0]    hdr_dest;
    logic [33:0]   head;
    logic [1:0]    head_dest;
    logic [3:0]    rd_vec;
    logic [3:0]    valid_vec;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    // Ready comes only from registered occupancy, so a pop on this edge
    // cannot make room for a push on the same edge.
    assign bus.INPUT_READY = !rst && !full;
    assign accept    = bus.INPUT_VALID && bus.INPUT_READY;

    assign hdr_len   = bus.INPUT_PORT[23:8];
    assign hdr_dest  = bus.INPUT_PORT[25:24];

    always_comb begin
        push      = 1'b0;
        push_dest = hdr_dest;
        if (accept) begin
            case (state)
                IDLE:    push = (hdr_len != 16'd0) && (hdr_len <= MAX_LEN);
                PAYLOAD: begin
                    push      = 1'b1;
                    push_dest = dest_q;
                end
                default: push = 1'b0;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign head_dest = head[33:32];
    assign rd_vec    = {bus.RD_4, bus.RD_3, bus.RD_2, bus.RD_1};

    // Only the head's destination can see valid, so at most one output is valid.
    always_comb begin
        valid_vec = 4'b0000;
        if (!empty)
            valid_vec[head_dest] = 1'b1;
    end

    assign pop = !empty && rd_vec[head_dest];

    assign bus.NOBLOCKOBUF_TO_1 = {valid_vec[0], valid_vec[0] ? head[31:0] : 32'd0};
    assign bus.NOBLOCKOBUF_TO_2 = {valid_vec[1], valid_vec[1] ? head[31:0] : 32'd0};
    assign bus.NOBLOCKOBUF_TO_3 = {valid_vec[2], valid_vec[2] ? head[31:0] : 32'd0};
    assign bus.NOBLOCKOBUF_TO_4 = {valid_vec[3], valid_vec[3] ? head[31:0] : 32'd0};

    // Storage needs no reset: the occupancy count gates everything read from it.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {push_dest, bus.INPUT_PORT};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 16'd0;
            dest_q <= 2'd0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (hdr_len == 16'd0) begin
                        state <= IDLE;
                    end else if (hdr_len > MAX_LEN) begin
                        cnt <= hdr_len - 16'd1;
                        if (hdr_len != 16'd1)
                            state <= DROP;
                    end else if (hdr_len != 16'd1) begin
                        dest_q <= hdr_dest;
                        cnt    <= hdr_len - 16'd1;
                        state  <= PAYLOAD;
                    end
                end
                PAYLOAD, DROP: begin
                    cnt <= cnt - 16'd1;
                    if (cnt == 16'd1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INPUT_DAEMON_DROP_CNT_EN
    logic drop_hit;

    // A header is counted when discarded for zero length or when it opens a DROP run.
    assign drop_hit = accept && (state == IDLE) &&
                      ((hdr_len == 16'd0) || ((hdr_len > MAX_LEN) && (hdr_len != 16'd1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            DROP_COUNT <= 16'd0;
        else if (drop_hit && (DROP_COUNT != 16'hFFFF))
            DROP_COUNT <= DROP_COUNT + 16'd1;
    end
`endif
endmodule

// File: tb/tb_input_daemon.sv
// tb/tb_input_daemon.sv - scoreboard testbench for input_daemon
module tb_input_daemon;
    logic clk;
    logic rst;

    input_daemon_if bus ();

`ifdef INPUT_DAEMON_DROP_CNT_EN
    logic [15:0] drop_count;
    input_daemon #(.DEPTH(16), .MAX_PKT_LEN(255)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .DROP_COUNT(drop_count)
    );
`else
    input_daemon #(.DEPTH(16), .MAX_PKT_LEN(255)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected popped entries, {dest[1:0], data[31:0]}, in arrival order
    logic [33:0] sb [$];

    logic [32:0] outs [4];
    logic [3:0]  rdv;
    assign outs[0] = bus.NOBLOCKOBUF_TO_1;
    assign outs[1] = bus.NOBLOCKOBUF_TO_2;
    assign outs[2] = bus.NOBLOCKOBUF_TO_3;
    assign outs[3] = bus.NOBLOCKOBUF_TO_4;
    assign rdv     = {bus.RD_4, bus.RD_3, bus.RD_2, bus.RD_1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pop-side scoreboard: a valid output with its strobe high pops on the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            int nvalid;
            logic bad;
            nvalid = 0;
            bad    = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (outs[k][32])
                    nvalid++;
                else if (outs[k] != 33'd0)
                    bad = 1'b1;
            end
            if (nvalid > 1)
                bad = 1'b1;
            check("out_form", {63'd0, bad}, 64'd0);
            for (int k = 0; k < 4; k++) begin
                if (outs[k][32] && rdv[k]) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 64'(sb.size()), 64'd1);
                    end else begin
                        logic [33:0] exp;
                        logic [1:0]  kd;
                        exp = sb.pop_front();
                        kd  = 2'(k);
                        check("pop", {30'd0, kd, outs[k][31:0]}, {30'd0, exp});
                    end
                end
            end
        end
    end

    task automatic set_rd(input logic [3:0] v);
        bus.RD_1 = v[0];
        bus.RD_2 = v[1];
        bus.RD_3 = v[2];
        bus.RD_4 = v[3];
    endtask

    // Present one word and hold it until an edge accepts it; returns #1 after that edge.
    task automatic send(input logic [31:0] d);
        logic r;
        logic acc;
        acc = 1'b0;
        bus.INPUT_PORT  = d;
        bus.INPUT_VALID = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            r = bus.INPUT_READY;
            @(posedge clk);
            #1;
            if (r)
                acc = 1'b1;
        end
        bus.INPUT_VALID = 1'b0;
        if (!acc)
            check("send_accept", {63'd0, acc}, 64'd1);
    endtask

    task automatic send_pkt(input logic [1:0] dest, input logic [15:0] len,
                            input int nwords, input bit expect_out);
        logic [31:0] w;
        for (int i = 0; i < nwords; i++) begin
            if (i == 0)
                w = {6'h15, dest, len, 8'hA5};
            else
                w = $urandom;
            if (expect_out)
                sb.push_back({dest, w});
            send(w);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++)
            @(posedge clk);
        #1;
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_outs_zero(input string tag);
        for (int k = 0; k < 4; k++)
            check(tag, {31'd0, outs[k]}, 64'd0);
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        bus.INPUT_PORT  = 32'd0;
        bus.INPUT_VALID = 1'b0;
        set_rd(4'b0000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {63'd0, bus.INPUT_READY}, 64'd0);
        check_outs_zero("rst_out");
`ifdef INPUT_DAEMON_DROP_CNT_EN
        check("rst_drop_count", {48'd0, drop_count}, 64'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", {63'd0, bus.INPUT_READY}, 64'd1);

        // Header to output 3 with two data words; visible right after its accept edge
        set_rd(4'b0100);
        sb.push_back({2'd2, 32'h0200_0300});
        send(32'h0200_0300);
        check("first_latency", {31'd0, bus.NOBLOCKOBUF_TO_3}, 64'h1_0200_0300);
        check("first_to1", {31'd0, bus.NOBLOCKOBUF_TO_1}, 64'd0);
        w = 32'hDEAD_0001; sb.push_back({2'd2, w}); send(w);
        w = 32'hBEEF_0002; sb.push_back({2'd2, w}); send(w);
        wait_drain();

        // Head-of-line: B to output 4 waits behind A to output 1
        set_rd(4'b1000);
        send_pkt(2'd0, 16'd2, 2, 1'b1);
        send_pkt(2'd3, 16'd2, 2, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("hol_to4_blocked", {63'd0, bus.NOBLOCKOBUF_TO_4[32]}, 64'd0);
            check("hol_to1_valid", {63'd0, bus.NOBLOCKOBUF_TO_1[32]}, 64'd1);
        end
        @(posedge clk);
        #1;
        set_rd(4'b1001);
        wait_drain();

        // Fill to DEPTH, 17th word waits for the first pop
        set_rd(4'b0000);
        send_pkt(2'd1, 16'd17, 16, 1'b1);
        check("full_ready", {63'd0, bus.INPUT_READY}, 64'd0);
        w = 32'h1717_1717;
        sb.push_back({2'd1, w});
        bus.INPUT_PORT  = w;
        bus.INPUT_VALID = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_hold", {63'd0, bus.INPUT_READY}, 64'd0);
        end
        @(posedge clk);
        #1;
        set_rd(4'b0010);
        @(negedge clk);
        check("pop_edge_no_room", {63'd0, bus.INPUT_READY}, 64'd0);
        @(negedge clk);
        check("room_after_pop", {63'd0, bus.INPUT_READY}, 64'd1);
        @(posedge clk);
        #1;
        bus.INPUT_VALID = 1'b0;
        wait_drain();

        // Drops: zero length, over-long packet, then a legal packet
        set_rd(4'b1111);
        send_pkt(2'd0, 16'd0, 1, 1'b0);
        send_pkt(2'd3, 16'd300, 300, 1'b0);
        send_pkt(2'd1, 16'd2, 2, 1'b1);
        wait_drain();
`ifdef INPUT_DAEMON_DROP_CNT_EN
        check("drop_count", {48'd0, drop_count}, 64'd2);
`endif

        // Reset mid-payload with 5 words buffered
        set_rd(4'b0000);
        send_pkt(2'd0, 16'd8, 5, 1'b0);
        check("buffered_head", {63'd0, bus.NOBLOCKOBUF_TO_1[32]}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_ready", {63'd0, bus.INPUT_READY}, 64'd0);
        check_outs_zero("midrst_out");
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
`ifdef INPUT_DAEMON_DROP_CNT_EN
        check("midrst_drop_count", {48'd0, drop_count}, 64'd0);
`endif
        set_rd(4'b1111);
        send_pkt(2'd2, 16'd1, 1, 1'b1);
        wait_drain();

        // Strobe for the wrong output does not pop the head
        set_rd(4'b0000);
        send_pkt(2'd0, 16'd1, 1, 1'b1);
        w = {6'h15, 2'd0, 16'd1, 8'hA5};
        set_rd(4'b0010);
        repeat (3) begin
            @(negedge clk);
            check("wrong_rd_head", {31'd0, bus.NOBLOCKOBUF_TO_1}, {31'd0, 1'b1, w});
        end
        @(posedge clk);
        #1;
        set_rd(4'b0001);
        wait_drain();
        set_rd(4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check_outs_zero("end_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
